// File: rtl/risc_pkg.sv
// Shared widths and ALU operation encodings for the integer pipeline.
package risc_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 5;
    localparam int unsigned ALU_CTRL_WIDTH = 3;

    typedef enum logic [ALU_CTRL_WIDTH-1:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100
    } alu_ctrl_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass select: the EX/MEM result beats the MEM/WB result, which beats
// register-file data. Register index zero never bypasses.
module fwd_mux #(
    parameter int unsigned DATA_WIDTH = risc_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = risc_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  mem_reg_write,
    input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] fwd_data_c
);

    logic rs_nonzero_c;
    logic mem_hit_c;
    logic wb_hit_c;

    assign rs_nonzero_c = (rs_addr != '0);
    assign mem_hit_c    = rs_nonzero_c && mem_reg_write && (mem_rd_addr == rs_addr);
    assign wb_hit_c     = rs_nonzero_c && wb_reg_write  && (wb_rd_addr  == rs_addr);

    always_comb begin
        fwd_data_c = rf_data;
        if (mem_hit_c) begin
            fwd_data_c = mem_result;
        end else if (wb_hit_c) begin
            fwd_data_c = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, bypassing at capture and
// a writeback snoop that keeps stalled operands current.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = risc_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = risc_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_alu_src,
    input  logic [2:0]            id_alu_ctrl,
    input  logic                  id_reg_write,
    input  logic                  mem_reg_write,
    input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_result,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] wb_result,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                  ex_reg_write
);

    logic                  ex_valid_q,  ex_valid_d;
    logic [DATA_WIDTH-1:0] alu_op1_q,   alu_op1_d;
    logic [DATA_WIDTH-1:0] alu_op2_q,   alu_op2_d;
    logic [2:0]            alu_ctrl_q,  alu_ctrl_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] rs1_addr_q,  rs1_addr_d;
    logic [ADDR_WIDTH-1:0] rs2_addr_q,  rs2_addr_d;
    logic                  alu_src_q,   alu_src_d;

    logic                  capture_c;
    logic                  hold_c;
    logic                  snoop1_c;
    logic                  snoop2_c;
    logic [DATA_WIDTH-1:0] fwd_rs1_c;
    logic [DATA_WIDTH-1:0] fwd_rs2_c;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs1 (
        .rs_addr       (id_rs1_addr),
        .rf_data       (id_rs1_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data_c    (fwd_rs1_c)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs2 (
        .rs_addr       (id_rs2_addr),
        .rf_data       (id_rs2_data),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data_c    (fwd_rs2_c)
    );

    assign id_ready  = (!ex_valid_q || ex_ready) && !flush;
    assign capture_c = id_valid && id_ready;
    assign hold_c    = ex_valid_q && !ex_ready;

    // Only the writeback port is snooped while stalled; an immediate operand is never replaced.
    assign snoop1_c = wb_reg_write && (rs1_addr_q != '0) && (wb_rd_addr == rs1_addr_q);
    assign snoop2_c = wb_reg_write && !alu_src_q && (rs2_addr_q != '0) && (wb_rd_addr == rs2_addr_q);

    always_comb begin
        ex_valid_d  = ex_valid_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_ctrl_d  = alu_ctrl_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        alu_src_d   = alu_src_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture_c) begin
            ex_valid_d  = 1'b1;
            alu_op1_d   = fwd_rs1_c;
            alu_op2_d   = id_alu_src ? id_imm : fwd_rs2_c;
            alu_ctrl_d  = id_alu_ctrl;
            rd_addr_d   = id_rd_addr;
            reg_write_d = id_reg_write;
            rs1_addr_d  = id_rs1_addr;
            rs2_addr_d  = id_rs2_addr;
            alu_src_d   = id_alu_src;
        end else if (hold_c) begin
            if (snoop1_c) begin
                alu_op1_d = wb_result;
            end
            if (snoop2_c) begin
                alu_op2_d = wb_result;
            end
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_ctrl_q  <= risc_pkg::ADD;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            alu_src_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            alu_src_q   <= alu_src_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ALUop1       = alu_op1_q;
    assign ALUop2       = alu_op2_q;
    assign ALUctrl      = alu_ctrl_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model predicts each registered
// output set, which is queued at drive time and compared after the clock edge.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [2:0]    ctrl;
        logic [AW-1:0] rd;
        logic          rw;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic          id_alu_src;
    logic [2:0]    id_alu_ctrl;
    logic          id_reg_write;
    logic          mem_reg_write;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_result;
    logic          wb_reg_write;
    logic [AW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_result;
    logic          flush;
    logic          ex_ready;
    logic          ex_valid;
    logic [DW-1:0] ALUop1, ALUop2;
    logic [2:0]    ALUctrl;
    logic [AW-1:0] ex_rd_addr;
    logic          ex_reg_write;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mdl = '0;
    logic [AW-1:0] m_rs1 = '0, m_rs2 = '0;
    logic          m_src = 1'b0;

    id_ex_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        return {ex_valid, ALUop1, ALUop2, ALUctrl, ex_rd_addr, ex_reg_write};
    endfunction

    function automatic logic [DW-1:0] ref_fwd(input logic [AW-1:0] rs, input logic [DW-1:0] d);
        if (rs == '0) return d;
        if (mem_reg_write && mem_rd_addr == rs) return mem_result;
        if (wb_reg_write && wb_rd_addr == rs) return wb_result;
        return d;
    endfunction

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_src = 0;
        id_alu_ctrl = 3'b000; id_reg_write = 0;
        mem_reg_write = 0; mem_rd_addr = '0; mem_result = '0;
        wb_reg_write = 0; wb_rd_addr = '0; wb_result = '0;
        flush = 0; ex_ready = 1;
    endtask

    // Predict the next registered state from current inputs, queue it, advance one cycle.
    task automatic apply();
        exp_t nx;
        logic rdy;
        nx  = mdl;
        rdy = (!mdl.v || ex_ready) && !flush;
        if (rst) begin
            nx = '0; m_rs1 = '0; m_rs2 = '0; m_src = 1'b0;
        end else if (flush) begin
            nx.v = 1'b0;
        end else if (id_valid && rdy) begin
            nx.v    = 1'b1;
            nx.op1  = ref_fwd(id_rs1_addr, id_rs1_data);
            nx.op2  = id_alu_src ? id_imm : ref_fwd(id_rs2_addr, id_rs2_data);
            nx.ctrl = id_alu_ctrl;
            nx.rd   = id_rd_addr;
            nx.rw   = id_reg_write;
            m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr; m_src = id_alu_src;
        end else if (mdl.v && !ex_ready) begin
            if (wb_reg_write && m_rs1 != '0 && wb_rd_addr == m_rs1) nx.op1 = wb_result;
            if (wb_reg_write && !m_src && m_rs2 != '0 && wb_rd_addr == m_rs2) nx.op2 = wb_result;
        end else begin
            nx.v = 1'b0;
        end
        mdl = nx;
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t got, exp;
        clear_inputs();
        rst = 1;
        apply();
        apply();
        void'(exp_q.pop_front());
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== '0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", got, exp);
        end
        rst = 0;
        #1; checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_id_ready got=%b exp=1", id_ready);
        end
    endtask

    task automatic test_capture();
        exp_t got, exp;
        clear_inputs();
        id_valid = 1; id_rs1_addr = 3; id_rs1_data = 5; id_rs2_addr = 4; id_rs2_data = 7;
        id_alu_ctrl = 3'b000; id_rd_addr = 1; id_reg_write = 1;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin
            errors++; $display("FAIL capture_sb got=%h exp=%h", got, exp);
        end
        checks++;
        if (ex_valid !== 1'b1 || ALUop1 !== 32'd5 || ALUop2 !== 32'd7 || ALUctrl !== 3'b000) begin
            errors++; $display("FAIL capture_direct got v=%b op1=%h op2=%h ctrl=%b exp v=1 op1=5 op2=7 ctrl=000",
                               ex_valid, ALUop1, ALUop2, ALUctrl);
        end
    endtask

    task automatic test_priority();
        exp_t got, exp;
        clear_inputs();
        id_valid = 1; id_rs1_addr = 6; id_rs1_data = 32'h99; id_rs2_addr = 2; id_rs2_data = 32'h3;
        mem_reg_write = 1; mem_rd_addr = 6; mem_result = 32'h11;
        wb_reg_write = 1; wb_rd_addr = 6; wb_result = 32'h22;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop1 !== 32'h11) begin
            errors++; $display("FAIL prio_mem got=%h exp=%h op1=%h req=11", got, exp, ALUop1);
        end
        mem_reg_write = 0;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop1 !== 32'h22) begin
            errors++; $display("FAIL prio_wb got=%h exp=%h op1=%h req=22", got, exp, ALUop1);
        end
    endtask

    task automatic test_x0();
        exp_t got, exp;
        clear_inputs();
        id_valid = 1; id_rs1_addr = 0; id_rs1_data = 0;
        mem_reg_write = 1; mem_rd_addr = 0; mem_result = 32'hFF;
        wb_reg_write = 1; wb_rd_addr = 0; wb_result = 32'hEE;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop1 !== 32'h0) begin
            errors++; $display("FAIL x0_zero got=%h exp=%h op1=%h req=0", got, exp, ALUop1);
        end
        id_rs1_data = 32'h5A; id_rs2_addr = 0; id_rs2_data = 32'hA5;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop1 !== 32'h5A || ALUop2 !== 32'hA5) begin
            errors++; $display("FAIL x0_data got=%h exp=%h op1=%h op2=%h req=5a/a5", got, exp, ALUop1, ALUop2);
        end
    endtask

    task automatic test_stall_snoop();
        exp_t got, exp;
        clear_inputs();
        id_valid = 1; id_rs1_addr = 2; id_rs1_data = 32'h10; id_rs2_addr = 9; id_rs2_data = 32'h1;
        id_alu_ctrl = 3'b001; id_rd_addr = 4; id_reg_write = 1;
        apply();
        void'(exp_q.pop_front());
        ex_ready = 0;
        id_rs1_addr = 7; id_rs1_data = 32'h99; id_alu_ctrl = 3'b011; id_rd_addr = 8;
        wb_reg_write = 1; wb_rd_addr = 9; wb_result = 32'h40;
        #1; checks++;
        if (id_ready !== 1'b0) begin
            errors++; $display("FAIL stall_id_ready got=%b exp=0", id_ready);
        end
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop2 !== 32'h40 || ALUop1 !== 32'h10 || ALUctrl !== 3'b001 || ex_rd_addr !== 5'd4) begin
            errors++; $display("FAIL snoop_wb got=%h exp=%h", got, exp);
        end
        wb_reg_write = 0; mem_reg_write = 1; mem_rd_addr = 9; mem_result = 32'h77;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop2 !== 32'h40) begin
            errors++; $display("FAIL snoop_no_mem got=%h exp=%h op2=%h req=40", got, exp, ALUop2);
        end
        mem_reg_write = 0; ex_ready = 1;
        id_rs1_addr = 2; id_rs1_data = 32'h10; id_alu_src = 1; id_imm = 32'h123;
        apply();
        void'(exp_q.pop_front());
        ex_ready = 0; wb_reg_write = 1; wb_rd_addr = 9; wb_result = 32'h40;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ALUop2 !== 32'h123) begin
            errors++; $display("FAIL snoop_imm got=%h exp=%h op2=%h req=123", got, exp, ALUop2);
        end
    endtask

    task automatic test_flush();
        exp_t got, exp;
        flush = 1; id_valid = 1; ex_ready = 0;
        #1; checks++;
        if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL flush_id_ready got rdy=%b v=%b exp rdy=0 v=1", id_ready, ex_valid);
        end
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || ex_valid !== 1'b0 || ALUop2 !== 32'h123) begin
            errors++; $display("FAIL flush_clear got=%h exp=%h", got, exp);
        end
        flush = 0;
    endtask

    task automatic test_reset_mid_stall();
        exp_t got, exp;
        clear_inputs();
        id_valid = 1; id_rs1_addr = 5; id_rs1_data = 32'hAB; id_rs2_addr = 6; id_rs2_data = 32'hCD;
        id_alu_ctrl = 3'b100; id_rd_addr = 12; id_reg_write = 1;
        apply();
        void'(exp_q.pop_front());
        ex_ready = 0; rst = 1; flush = 1;
        apply();
        got = observed(); exp = exp_q.pop_front(); checks++;
        if (got !== exp || got !== '0) begin
            errors++; $display("FAIL reset_mid_stall got=%h exp=%h", got, exp);
        end
        rst = 0; flush = 0;
        #1; checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got=%b exp=1", id_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        logic exp_rdy;
        clear_inputs();
        for (int i = 0; i < 60; i++) begin
            id_valid     = 1'($urandom_range(0, 3) != 0);
            id_rs1_addr  = AW'($urandom_range(0, 3));
            id_rs2_addr  = AW'($urandom_range(0, 3));
            id_rd_addr   = AW'($urandom_range(0, 31));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_src   = 1'($urandom_range(0, 1));
            id_alu_ctrl  = 3'($urandom_range(0, 4));
            id_reg_write = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_rd_addr  = AW'($urandom_range(0, 3));
            mem_result   = $urandom;
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_rd_addr   = AW'($urandom_range(0, 3));
            wb_result    = $urandom;
            ex_ready     = 1'($urandom_range(0, 2) != 0);
            flush        = 1'($urandom_range(0, 9) == 0);
            #1;
            exp_rdy = (!mdl.v || ex_ready) && !flush;
            checks++;
            if (id_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, id_ready, exp_rdy);
            end
            apply();
            got = observed(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++; $display("FAIL b2b_sb[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_capture();
        test_priority();
        test_x0();
        test_stall_snoop();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
